uart_cpu_link_ctrl: RTL and testbench



---
 rtl/uart_cpu_link_ctrl.sv | 122 ++++++++++++
 tb/tb_uart_cpu_link_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cpu_link_ctrl.sv
// UART-to-CPU link controller: buffers received bytes, presents them one at a
// time with an interrupt/acknowledge handshake, and holds the CPU-written LED register.
module uart_cpu_link_ctrl #(
   parameter int DEPTH   = 4,
   parameter int AW      = 2,
   parameter int TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   input  logic          rx_frame_err,
   output logic [7:0]    uart_to_cpu_buf,
   output logic          read_int,
   input  logic          cpu_end_read,
   output logic [AW:0]   fifo_level,
   output logic          overrun,
   output logic [7:0]    err_count,
   input  logic [7:0]    leds_array,
   input  logic          write_leds,
   output logic [7:0]    leds
);

   typedef enum logic [1:0] {IDLE, PRESENT, WAIT_ACK, RELEASE} state_t;

   state_t          state_reg;
   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [AW:0]     level_reg;
   logic [15:0]     timer_reg;
   logic            ack_prev_reg;
   logic            leds_prev_reg;

   logic ack_rise;
   logic full;
   logic good;
   logic pop;
   logic push;

   assign ack_rise   = cpu_end_read & ~ack_prev_reg;
   assign full       = (level_reg == (AW+1)'(DEPTH));
   assign good       = rx_valid & ~rx_frame_err;
   assign pop        = (state_reg == WAIT_ACK) && ack_rise;
   // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
   assign push       = good & (~full | pop);
   assign fifo_level = level_reg;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr_reg] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg       <= IDLE;
         wr_ptr_reg      <= '0;
         rd_ptr_reg      <= '0;
         level_reg       <= '0;
         timer_reg       <= '0;
         ack_prev_reg    <= 1'b0;
         leds_prev_reg   <= 1'b0;
         uart_to_cpu_buf <= 8'h00;
         read_int        <= 1'b0;
         overrun         <= 1'b0;
         err_count       <= 8'h00;
         leds            <= 8'h00;
      end else begin
         ack_prev_reg  <= cpu_end_read;
         leds_prev_reg <= write_leds;
         if (write_leds && !leds_prev_reg)
            leds <= leds_array;

         if (push)
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   level_reg <= level_reg + 1'b1;
            2'b01:   level_reg <= level_reg - 1'b1;
            default: level_reg <= level_reg;
         endcase

         if (good && full && !pop)
            overrun <= 1'b1;
         if (rx_valid && rx_frame_err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;

         read_int <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (level_reg != '0) begin
                  uart_to_cpu_buf <= mem[rd_ptr_reg];
                  read_int        <= 1'b1;
                  state_reg       <= PRESENT;
               end
            end
            PRESENT: begin
               timer_reg <= '0;
               state_reg <= WAIT_ACK;
            end
            WAIT_ACK: begin
               // Acknowledge wins over a timeout landing on the same edge.
               if (ack_rise) begin
                  state_reg <= RELEASE;
               end else if (timer_reg == 16'(TIMEOUT - 1)) begin
                  read_int  <= 1'b1;
                  state_reg <= PRESENT;
               end else begin
                  timer_reg <= timer_reg + 16'd1;
               end
            end
            RELEASE: begin
               if (!cpu_end_read)
                  state_reg <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_cpu_link_ctrl.sv
// Directed bench for uart_cpu_link_ctrl (DEPTH=4, TIMEOUT=10).
module tb_uart_cpu_link_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_valid = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_frame_err = 1'b0;
   logic [7:0] uart_to_cpu_buf;
   logic       read_int;
   logic       cpu_end_read = 1'b0;
   logic [2:0] fifo_level;
   logic       overrun;
   logic [7:0] err_count;
   logic [7:0] leds_array = 8'h00;
   logic       write_leds = 1'b0;
   logic [7:0] leds;

   int errors = 0;
   int checks = 0;
   int pulses = 0;
   int p0;
   logic ri_d = 1'b0;
   logic consec = 1'b0;

   uart_cpu_link_ctrl #(.DEPTH(4), .AW(2), .TIMEOUT(10)) dut (
      .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
      .rx_frame_err(rx_frame_err), .uart_to_cpu_buf(uart_to_cpu_buf),
      .read_int(read_int), .cpu_end_read(cpu_end_read), .fifo_level(fifo_level),
      .overrun(overrun), .err_count(err_count), .leds_array(leds_array),
      .write_leds(write_leds), .leds(leds)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (read_int) pulses <= pulses + 1;
      ri_d <= read_int;
      if (read_int && ri_d) consec <= 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end else begin
         $display("ok   %s: %0h", tag, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      tick();
      rx_valid = 1'b0;
   endtask

   // Ack from WAIT_ACK, then wait until the next byte (if any) is in WAIT_ACK.
   task automatic ack_byte();
      cpu_end_read = 1'b1;
      tick();
      tick();
      cpu_end_read = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      // Reset with rx_valid pulsing
      p0 = pulses;
      for (int i = 0; i < 6; i++) begin
         rx_valid = i[0];
         rx_data  = 8'hEE;
         tick();
      end
      rx_valid = 1'b0;
      check("rst_level", fifo_level, 0);
      check("rst_buf", uart_to_cpu_buf, 0);
      check("rst_leds", leds, 0);
      check("rst_err", err_count, 0);
      check("rst_pulses", pulses - p0, 0);
      rst_n = 1'b1;
      tick();

      // First byte latency
      push(8'hA5);
      check("lat_n_int", read_int, 0);
      check("lat_n_level", fifo_level, 1);
      tick();
      check("lat_n1_int", read_int, 1);
      check("lat_n1_buf", uart_to_cpu_buf, 8'hA5);
      tick();
      check("lat_n2_int", read_int, 0);
      cpu_end_read = 1'b1;
      tick();
      tick();
      cpu_end_read = 1'b0;
      tick();
      tick();
      check("a5_drained", fifo_level, 0);

      // Three bytes in order
      p0 = pulses;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      check("seq_buf0", uart_to_cpu_buf, 8'h11);
      check("seq_lvl0", fifo_level, 3);
      ack_byte();
      check("seq_buf1", uart_to_cpu_buf, 8'h22);
      check("seq_lvl1", fifo_level, 2);
      ack_byte();
      check("seq_buf2", uart_to_cpu_buf, 8'h33);
      check("seq_lvl2", fifo_level, 1);
      ack_byte();
      check("seq_lvl3", fifo_level, 0);
      check("seq_buf_kept", uart_to_cpu_buf, 8'h33);
      check("seq_pulses", pulses - p0, 3);

      // Overrun, then push on the same edge as a pop with a full FIFO
      push(8'hA1);
      push(8'hA2);
      push(8'hA3);
      push(8'hA4);
      push(8'hA5);
      check("ovr_level", fifo_level, 4);
      check("ovr_flag", overrun, 1);
      rx_valid = 1'b1;
      rx_data = 8'hB6;
      cpu_end_read = 1'b1;
      tick();
      rx_valid = 1'b0;
      check("fullpop_level", fifo_level, 4);
      check("fullpop_ovr", overrun, 1);
      tick();
      cpu_end_read = 1'b0;
      repeat (4) tick();
      check("ovr_buf_a2", uart_to_cpu_buf, 8'hA2);
      ack_byte();
      check("ovr_buf_a3", uart_to_cpu_buf, 8'hA3);
      ack_byte();
      check("ovr_buf_a4", uart_to_cpu_buf, 8'hA4);
      ack_byte();
      check("ovr_buf_b6", uart_to_cpu_buf, 8'hB6);
      ack_byte();
      check("ovr_drained", fifo_level, 0);

      // Frame errors saturate
      p0 = pulses;
      rx_valid = 1'b1;
      rx_frame_err = 1'b1;
      rx_data = 8'h5C;
      repeat (300) tick();
      rx_valid = 1'b0;
      rx_frame_err = 1'b0;
      tick();
      check("ferr_count", err_count, 255);
      check("ferr_level", fifo_level, 0);
      check("ferr_pulses", pulses - p0, 0);

      // Timeout re-pulse, then ack on the timeout edge
      push(8'h5A);
      tick();
      check("to_first", read_int, 1);
      repeat (10) tick();
      check("to_quiet", read_int, 0);
      tick();
      check("to_repulse", read_int, 1);
      check("to_buf", uart_to_cpu_buf, 8'h5A);
      repeat (10) tick();
      cpu_end_read = 1'b1;
      tick();
      check("to_ack_int", read_int, 0);
      check("to_ack_level", fifo_level, 0);
      cpu_end_read = 1'b0;
      repeat (3) tick();

      // Reset mid-handshake with ack held high through release
      push(8'h77);
      tick();
      tick();
      cpu_end_read = 1'b1;
      rst_n = 1'b0;
      tick();
      tick();
      check("mid_rst_level", fifo_level, 0);
      check("mid_rst_buf", uart_to_cpu_buf, 0);
      check("mid_rst_ovr", overrun, 0);
      check("mid_rst_err", err_count, 0);
      rst_n = 1'b1;
      push(8'h88);
      repeat (4) tick();
      check("held_no_pop", fifo_level, 1);
      check("held_buf", uart_to_cpu_buf, 8'h88);
      cpu_end_read = 1'b0;
      tick();
      cpu_end_read = 1'b1;
      tick();
      check("rise_pop", fifo_level, 0);
      cpu_end_read = 1'b0;
      tick();
      tick();

      // LED register
      leds_array = 8'h3C;
      write_leds = 1'b1;
      tick();
      check("leds_latch", leds, 8'h3C);
      leds_array = 8'hC3;
      tick();
      check("leds_held", leds, 8'h3C);
      write_leds = 1'b0;
      tick();
      check("leds_low", leds, 8'h3C);
      write_leds = 1'b1;
      tick();
      check("leds_relatch", leds, 8'hC3);
      write_leds = 1'b0;
      tick();

      check("int_never_consec", consec, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
